// File: rtl/vector_sweep_pkg.sv
// vector_sweep_pkg: FSM state type, parameter limits and a clamp helper for the sweep controller
package vector_sweep_pkg;
  typedef enum logic [2:0] {IDLE, RST, APPLY, EMIT, DONE} state_e;
  localparam int SETTLE_MAX = 15;
  localparam int RST_CYC_MAX = 15;
  localparam int CNT_W = 4;
  function automatic int clamp(input int v, input int lo, input int hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction
endpackage

// File: rtl/sweep_wait_cnt.sv
// sweep_wait_cnt: loadable down-counter that parks at zero and flags it
module sweep_wait_cnt import vector_sweep_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/vector_sweep_ctrl.sv
// vector_sweep_ctrl: exhaustive input sweep of a single-output DUT with per-vector response records
module vector_sweep_ctrl import vector_sweep_pkg::*; #(
  parameter int WIDTH = 3,
  parameter int SETTLE = 1,
  parameter int RST_CYC = 1
) (
  input  logic                  CK,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [WIDTH-1:0]      vec_out,
  output logic                  dut_rst,
  input  logic                  dut_out,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [WIDTH-1:0]      rec_vec,
  output logic                  rec_resp,
  output logic [(1<<WIDTH)-1:0] resp_map,
  output logic                  busy,
  output logic                  done
);
  localparam int N = 1 << WIDTH;
  localparam logic [WIDTH-1:0] VMAX = WIDTH'(N - 1);
  localparam int S = clamp(SETTLE, 0, SETTLE_MAX);
  localparam int RC = clamp(RST_CYC, 1, RST_CYC_MAX);
  state_e state_q;
  logic [WIDTH-1:0] vec_q, rec_vec_q;
  logic [N-1:0] map_q;
  logic dut_rst_q, rec_valid_q, rec_resp_q, busy_q, done_q;
  logic cnt_load, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  // counter preloads with length-1 so the zero cycle is the last cycle of RST/APPLY
  assign cnt_load = !abort && ((state_q == IDLE && start) || (state_q == RST && cnt_zero) ||
                    (state_q == EMIT && rec_ready && vec_q != VMAX));
  assign cnt_val = state_q == IDLE ? CNT_W'(RC - 1) : CNT_W'(S);
  sweep_wait_cnt u_cnt (
    .clk(CK),
    .rst(reset),
    .load_i(cnt_load),
    .val_i(cnt_val),
    .zero_o(cnt_zero)
  );
  always_ff @(posedge CK) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q <= '0;
      rec_vec_q <= '0;
      map_q <= '0;
      dut_rst_q <= 1'b0;
      rec_valid_q <= 1'b0;
      rec_resp_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
      dut_rst_q <= 1'b0;
      rec_valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= RST;
          vec_q <= '0;
          map_q <= '0;
          dut_rst_q <= 1'b1;
          busy_q <= 1'b1;
        end
        RST: if (cnt_zero) begin
          state_q <= APPLY;
          dut_rst_q <= 1'b0;
        end
        APPLY: if (cnt_zero) begin
          state_q <= EMIT;
          rec_resp_q <= dut_out;
          map_q[vec_q] <= dut_out;
          rec_vec_q <= vec_q;
          rec_valid_q <= 1'b1;
        end
        EMIT: if (rec_ready) begin
          rec_valid_q <= 1'b0;
          if (vec_q == VMAX) state_q <= DONE;
          else begin
            state_q <= APPLY;
            vec_q <= vec_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign vec_out = vec_q;
  assign dut_rst = dut_rst_q;
  assign rec_valid = rec_valid_q;
  assign rec_vec = rec_vec_q;
  assign rec_resp = rec_resp_q;
  assign resp_map = map_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_vector_sweep_ctrl.sv
// tb_vector_sweep_ctrl: directed checks of the sweep controller against a parity-style DUT model
module tb_vector_sweep_ctrl;
  logic CK = 0, reset = 1, start = 0, abort = 0, rec_ready = 1, start1 = 0;
  logic [2:0] vec_out, rec_vec, vec_out1, rec_vec1;
  logic [7:0] resp_map, resp_map1;
  logic dut_rst, rec_valid, rec_resp, busy, done, dut_out;
  logic dut_rst1, rec_valid1, rec_resp1, busy1, done1, dut_out1;
  logic [7:0] exp_map = 8'h5A;
  int total = 0, bad = 0;
  assign dut_out = vec_out[0] ^ vec_out[2];
  assign dut_out1 = vec_out1[0] ^ vec_out1[2];
  always #5 CK = ~CK;
  vector_sweep_ctrl u0 (
    .CK(CK), .reset(reset), .start(start), .abort(abort), .vec_out(vec_out),
    .dut_rst(dut_rst), .dut_out(dut_out), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_vec(rec_vec), .rec_resp(rec_resp), .resp_map(resp_map), .busy(busy), .done(done)
  );
  vector_sweep_ctrl #(.WIDTH(3), .SETTLE(0), .RST_CYC(3)) u1 (
    .CK(CK), .reset(reset), .start(start1), .abort(abort), .vec_out(vec_out1),
    .dut_rst(dut_rst1), .dut_out(dut_out1), .rec_valid(rec_valid1), .rec_ready(rec_ready),
    .rec_vec(rec_vec1), .rec_resp(rec_resp1), .resp_map(resp_map1), .busy(busy1), .done(done1)
  );
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CK);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string t);
    chk({t, "_vec"}, 32'(vec_out), 0);
    chk({t, "_dut_rst"}, 32'(dut_rst), 0);
    chk({t, "_rec_valid"}, 32'(rec_valid), 0);
    chk({t, "_rec_vec"}, 32'(rec_vec), 0);
    chk({t, "_rec_resp"}, 32'(rec_resp), 0);
    chk({t, "_map"}, 32'(resp_map), 0);
    chk({t, "_busy"}, 32'(busy), 0);
    chk({t, "_done"}, 32'(done), 0);
  endtask
  // sv/sn: stall sn cycles on the record of vector sv; pv: pulse start when vec_out first equals pv
  task automatic sweep(input int sv, input int sn, input int pv, output int cyc, output int k);
    int hold = 0;
    bit pulsed = 0;
    start = 1;
    tick(1);
    start = 0;
    chk("start_dut_rst", 32'(dut_rst), 1);
    chk("start_busy", 32'(busy), 1);
    cyc = 0;
    k = 0;
    do begin
      tick(1);
      cyc++;
      start = pv >= 0 && !pulsed && vec_out == 3'(pv);
      if (start) pulsed = 1;
      if (rec_valid) begin
        chk("rec_vec", 32'(rec_vec), k);
        chk("rec_resp", 32'(rec_resp), 32'(exp_map[k[2:0]]));
        rec_ready = !(k == sv && hold < sn);
        if (rec_ready) k++;
        else hold++;
      end
    end while (!done && cyc < 200);
    start = 0;
    rec_ready = 1;
  endtask
  initial begin
    int cyc, k, n;
    start = 1;
    abort = 1;
    tick(2);
    start = 0;
    abort = 0;
    chk_zero("reset");
    reset = 0;
    sweep(-1, 0, -1, cyc, k);
    chk("full_done_cyc", cyc, 26);
    chk("full_recs", k, 8);
    chk("full_map", 32'(resp_map), 32'h5A);
    chk("full_busy_at_done", 32'(busy), 0);
    tick(1);
    chk("done_one_cycle", 32'(done), 0);
    chk("map_held", 32'(resp_map), 32'h5A);
    sweep(3, 5, -1, cyc, k);
    chk("stall_done_cyc", cyc, 31);
    chk("stall_recs", k, 8);
    chk("stall_map", 32'(resp_map), 32'h5A);
    tick(1);
    start = 1;
    abort = 1;
    tick(1);
    start = 0;
    abort = 0;
    chk("start_abort_busy", 32'(busy), 0);
    chk("start_abort_dut_rst", 32'(dut_rst), 0);
    start = 1;
    tick(1);
    start = 0;
    n = 0;
    while (vec_out != 3'd5 && n < 100) begin
      tick(1);
      n++;
    end
    chk("abort_reach_vec", 32'(vec_out), 5);
    chk("abort_in_apply", 32'(rec_valid), 0);
    abort = 1;
    tick(1);
    abort = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rec_valid", 32'(rec_valid), 0);
    chk("abort_dut_rst", 32'(dut_rst), 0);
    chk("abort_vec_held", 32'(vec_out), 5);
    chk("abort_map", 32'(resp_map), 32'h1A);
    n = 0;
    repeat (40) begin
      tick(1);
      n += int'(done) + int'(busy);
    end
    chk("abort_no_done", n, 0);
    start = 1;
    tick(1);
    start = 0;
    n = 0;
    while (!(rec_valid && rec_vec == 3'd2) && n < 100) begin
      tick(1);
      n++;
    end
    chk("emit_reach_vec", 32'(rec_vec), 2);
    reset = 1;
    tick(1);
    reset = 0;
    chk_zero("mid_reset");
    sweep(-1, 0, -1, cyc, k);
    chk("post_reset_done_cyc", cyc, 26);
    chk("post_reset_recs", k, 8);
    chk("post_reset_map", 32'(resp_map), 32'h5A);
    tick(1);
    sweep(-1, 0, 4, cyc, k);
    chk("busy_start_done_cyc", cyc, 26);
    chk("busy_start_recs", k, 8);
    tick(1);
    chk("busy_start_idle", 32'(busy), 0);
    chk("busy_start_no_second_done", 32'(done), 0);
    start1 = 1;
    tick(1);
    start1 = 0;
    n = int'(dut_rst1);
    cyc = 0;
    k = 0;
    do begin
      tick(1);
      cyc++;
      n += int'(dut_rst1);
      k += int'(rec_valid1);
    end while (!done1 && cyc < 200);
    chk("s0_dut_rst_cycles", n, 3);
    chk("s0_done_cyc", cyc, 20);
    chk("s0_recs", k, 8);
    chk("s0_map", 32'(resp_map1), 32'h5A);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
